// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//   Machine-mode trap sequencer. Accepts synchronous exceptions, the external
//   interrupt and mret, then walks the CSR file's single write port through the
//   trap-entry (mepc, mcause, mtval, mstatus) or trap-return (mstatus) updates
//   before issuing a PC redirect. While idle the write port is shared with
//   ex_stage. Shadow copies of mstatus/mie/mtvec/mepc follow every write this
//   block drives so that enables, vectoring and the mret target are known
//   locally.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   ex_csr_we/waddr/wdata           ex_stage CSR write request (IDLE only)
//   exc_valid/cause/pc/tval         synchronous exception from ex
//   irq_ext, irq_pc                 level external interrupt, resume PC
//   mret_valid                      mret in ex
//   csr_we/waddr/wdata              write port into the CSR file
//   stall, flush                    pipeline hold / kill in-flight
//   redirect_valid, redirect_pc     PC load request and target
// -----------------------------------------------------------------------------
module trap_ctrl #(
  parameter int CSR_ADDRESS_WIDTH = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ex_csr_we,
  input  logic [CSR_ADDRESS_WIDTH-1:0] ex_csr_waddr,
  input  logic [31:0]                  ex_csr_wdata,
  input  logic                         exc_valid,
  input  logic [31:0]                  exc_cause,
  input  logic [31:0]                  exc_pc,
  input  logic [31:0]                  exc_tval,
  input  logic                         irq_ext,
  input  logic [31:0]                  irq_pc,
  input  logic                         mret_valid,
  output logic                         csr_we,
  output logic [CSR_ADDRESS_WIDTH-1:0] csr_waddr,
  output logic [31:0]                  csr_wdata,
  output logic                         stall,
  output logic                         flush,
  output logic                         redirect_valid,
  output logic [31:0]                  redirect_pc
);

  localparam logic [CSR_ADDRESS_WIDTH-1:0] ADDR_MSTATUS = CSR_ADDRESS_WIDTH'(12'h300);
  localparam logic [CSR_ADDRESS_WIDTH-1:0] ADDR_MIE     = CSR_ADDRESS_WIDTH'(12'h304);
  localparam logic [CSR_ADDRESS_WIDTH-1:0] ADDR_MTVEC   = CSR_ADDRESS_WIDTH'(12'h305);
  localparam logic [CSR_ADDRESS_WIDTH-1:0] ADDR_MEPC    = CSR_ADDRESS_WIDTH'(12'h341);
  localparam logic [CSR_ADDRESS_WIDTH-1:0] ADDR_MCAUSE  = CSR_ADDRESS_WIDTH'(12'h342);
  localparam logic [CSR_ADDRESS_WIDTH-1:0] ADDR_MTVAL   = CSR_ADDRESS_WIDTH'(12'h343);

  localparam logic [31:0] IRQ_EXT_CAUSE = 32'h8000_000B;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_MEPC   = 3'd1,
    ST_W_MCAUSE = 3'd2,
    ST_W_MTVAL  = 3'd3,
    ST_W_MSTAT  = 3'd4,
    ST_R_MSTAT  = 3'd5,
    ST_REDIRECT = 3'd6
  } state_t;

  state_t state_r;
  state_t state_nxt;

  // Latched trap context and whether the pending redirect is an mret.
  logic [31:0] pc_r;
  logic [31:0] cause_r;
  logic [31:0] tval_r;
  logic        mret_r;

  // Shadows. Only MEIE of mie is ever consulted, so only that bit is kept.
  logic [31:0] mstatus_s;
  logic        mie_meie_s;
  logic [31:0] mtvec_s;
  logic [31:0] mepc_s;

  // Ungated combinational results; outputs are forced low while in reset.
  logic                         take_exc;
  logic                         take_irq;
  logic                         take_mret;
  logic                         we_c;
  logic [CSR_ADDRESS_WIDTH-1:0] waddr_c;
  logic [31:0]                  wdata_c;
  logic                         flush_c;
  logic                         rv_c;
  logic [31:0]                  rpc_c;
  logic                         irq_enabled;

  // mstatus on trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
  function automatic logic [31:0] mstatus_on_entry(input logic [31:0] m);
    logic [31:0] r;
    r        = m;
    r[7]     = m[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // mstatus on mret: MIE <- MPIE, MPIE <- 1, MPP <- M.
  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] m);
    logic [31:0] r;
    r        = m;
    r[3]     = m[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Trap vector: vectored mode only applies to interrupts; sum wraps at 32 bits.
  function automatic logic [31:0] trap_target(input logic [31:0] tvec,
                                              input logic [31:0] cause);
    logic [31:0] base;
    base = {tvec[31:2], 2'b00};
    if ((tvec[1:0] == 2'b01) && cause[31]) begin
      return base + 32'({cause[30:0], 2'b00});
    end else begin
      return base;
    end
  endfunction

  assign irq_enabled = irq_ext & mstatus_s[3] & mie_meie_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state, acceptance priority and write-port steering.
  always_comb begin
    state_nxt = state_r;
    take_exc  = 1'b0;
    take_irq  = 1'b0;
    take_mret = 1'b0;
    we_c      = 1'b0;
    waddr_c   = '0;
    wdata_c   = 32'h0;
    flush_c   = 1'b0;
    rv_c      = 1'b0;
    rpc_c     = 32'h0;
    case (state_r)
      ST_IDLE: begin
        if (exc_valid) begin
          // The exception kills the ex instruction, including its CSR write.
          take_exc  = 1'b1;
          flush_c   = 1'b1;
          state_nxt = ST_W_MEPC;
        end else begin
          if (ex_csr_we) begin
            we_c    = 1'b1;
            waddr_c = ex_csr_waddr;
            wdata_c = ex_csr_wdata;
          end else begin
            we_c    = 1'b0;
          end
          if (mret_valid) begin
            take_mret = 1'b1;
            flush_c   = 1'b1;
            state_nxt = ST_R_MSTAT;
          end else if (irq_enabled) begin
            take_irq  = 1'b1;
            flush_c   = 1'b1;
            state_nxt = ST_W_MEPC;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_W_MEPC: begin
        we_c      = 1'b1;
        waddr_c   = ADDR_MEPC;
        wdata_c   = pc_r;
        state_nxt = ST_W_MCAUSE;
      end
      ST_W_MCAUSE: begin
        we_c      = 1'b1;
        waddr_c   = ADDR_MCAUSE;
        wdata_c   = cause_r;
        state_nxt = ST_W_MTVAL;
      end
      ST_W_MTVAL: begin
        we_c      = 1'b1;
        waddr_c   = ADDR_MTVAL;
        wdata_c   = tval_r;
        state_nxt = ST_W_MSTAT;
      end
      ST_W_MSTAT: begin
        we_c      = 1'b1;
        waddr_c   = ADDR_MSTATUS;
        wdata_c   = mstatus_on_entry(mstatus_s);
        state_nxt = ST_REDIRECT;
      end
      ST_R_MSTAT: begin
        we_c      = 1'b1;
        waddr_c   = ADDR_MSTATUS;
        wdata_c   = mstatus_on_mret(mstatus_s);
        state_nxt = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        rv_c      = 1'b1;
        rpc_c     = mret_r ? mepc_s : trap_target(mtvec_s, cause_r);
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Trap context capture at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r    <= 32'h0;
      cause_r <= 32'h0;
      tval_r  <= 32'h0;
      mret_r  <= 1'b0;
    end else if (take_exc) begin
      pc_r    <= exc_pc;
      cause_r <= exc_cause;
      tval_r  <= exc_tval;
      mret_r  <= 1'b0;
    end else if (take_irq) begin
      pc_r    <= irq_pc;
      cause_r <= IRQ_EXT_CAUSE;
      tval_r  <= 32'h0;
      mret_r  <= 1'b0;
    end else if (take_mret) begin
      mret_r  <= 1'b1;
    end else begin
      mret_r  <= mret_r;
    end
  end

  // Shadows follow every write leaving this block, pass-through or generated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatus_s  <= 32'h0;
      mie_meie_s <= 1'b0;
      mtvec_s    <= 32'h0;
      mepc_s     <= 32'h0;
    end else if (we_c) begin
      case (waddr_c)
        ADDR_MSTATUS: mstatus_s  <= wdata_c;
        ADDR_MIE:     mie_meie_s <= wdata_c[11];
        ADDR_MTVEC:   mtvec_s    <= wdata_c;
        ADDR_MEPC:    mepc_s     <= wdata_c;
        default:      mstatus_s  <= mstatus_s;
      endcase
    end else begin
      mstatus_s <= mstatus_s;
    end
  end

  // Outputs drop to zero as soon as reset asserts, without waiting for a clock.
  assign csr_we         = rst_n & we_c;
  assign csr_waddr      = rst_n ? waddr_c : '0;
  assign csr_wdata      = rst_n ? wdata_c : 32'h0;
  assign stall          = rst_n & (state_r != ST_IDLE);
  assign flush          = rst_n & flush_c;
  assign redirect_valid = rst_n & rv_c;
  assign redirect_pc    = rst_n ? rpc_c : 32'h0;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_csr_we;
  logic [11:0] ex_csr_waddr;
  logic [31:0] ex_csr_wdata;
  logic        exc_valid;
  logic [31:0] exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        irq_ext;
  logic [31:0] irq_pc;
  logic        mret_valid;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int failures = 0;

  trap_ctrl #(.CSR_ADDRESS_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_csr_we(ex_csr_we), .ex_csr_waddr(ex_csr_waddr), .ex_csr_wdata(ex_csr_wdata),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .irq_ext(irq_ext), .irq_pc(irq_pc), .mret_valid(mret_valid),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ewe;
    logic [11:0] eaddr;
    logic [31:0] edata;
    logic        exc;
    logic [31:0] ecause;
    logic [31:0] epc;
    logic [31:0] etval;
    logic        irq;
    logic [31:0] ipc;
    logic        mret;
    logic        xwe;
    logic [11:0] xaddr;
    logic [31:0] xdata;
    logic        xstall;
    logic        xflush;
    logic        xrv;
    logic [31:0] xrpc;
  } vec_t;

  vec_t main_q[$];
  vec_t pre_q[$];
  vec_t post_q[$];

  function automatic vec_t mk(
    input logic ewe, input logic [11:0] eaddr, input logic [31:0] edata,
    input logic exc, input logic [31:0] ecause, input logic [31:0] epc, input logic [31:0] etval,
    input logic irq, input logic [31:0] ipc, input logic mret,
    input logic xwe, input logic [11:0] xaddr, input logic [31:0] xdata,
    input logic xstall, input logic xflush, input logic xrv, input logic [31:0] xrpc);
    vec_t v;
    v.ewe = ewe; v.eaddr = eaddr; v.edata = edata;
    v.exc = exc; v.ecause = ecause; v.epc = epc; v.etval = etval;
    v.irq = irq; v.ipc = ipc; v.mret = mret;
    v.xwe = xwe; v.xaddr = xaddr; v.xdata = xdata;
    v.xstall = xstall; v.xflush = xflush; v.xrv = xrv; v.xrpc = xrpc;
    return v;
  endfunction

  task automatic clear_inputs();
    ex_csr_we = 1'b0; ex_csr_waddr = 12'h0; ex_csr_wdata = 32'h0;
    exc_valid = 1'b0; exc_cause = 32'h0; exc_pc = 32'h0; exc_tval = 32'h0;
    irq_ext = 1'b0; irq_pc = 32'h0; mret_valid = 1'b0;
  endtask

  // Called at posedge+1: drive, compare at the falling edge, advance a cycle.
  task automatic run_vec(input vec_t v, input string name);
    logic ok;
    ex_csr_we = v.ewe; ex_csr_waddr = v.eaddr; ex_csr_wdata = v.edata;
    exc_valid = v.exc; exc_cause = v.ecause; exc_pc = v.epc; exc_tval = v.etval;
    irq_ext = v.irq; irq_pc = v.ipc; mret_valid = v.mret;
    #4;
    ok = (csr_we == v.xwe) && (stall == v.xstall) && (flush == v.xflush) &&
         (redirect_valid == v.xrv) && (redirect_pc == v.xrpc);
    if (v.xwe) ok = ok && (csr_waddr == v.xaddr) && (csr_wdata == v.xdata);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got we=%0b addr=%h data=%h stall=%0b flush=%0b rv=%0b rpc=%h, want we=%0b addr=%h data=%h stall=%0b flush=%0b rv=%0b rpc=%h",
               name, csr_we, csr_waddr, csr_wdata, stall, flush, redirect_valid, redirect_pc,
               v.xwe, v.xaddr, v.xdata, v.xstall, v.xflush, v.xrv, v.xrpc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (csr_we !== 1'b0 || csr_waddr !== 12'h0 || csr_wdata !== 32'h0 || stall !== 1'b0 ||
        flush !== 1'b0 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
      failures++;
      $display("FAIL %s: got we=%0b addr=%h data=%h stall=%0b flush=%0b rv=%0b rpc=%h, want all zero",
               name, csr_we, csr_waddr, csr_wdata, stall, flush, redirect_valid, redirect_pc);
    end
  endtask

  initial begin
    // Exception entry; exc_valid pulsed during W_MCAUSE must be ignored.
    main_q.push_back(mk(1'b1, 12'h305, 32'h100,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h305, 32'h100,  1'b0, 1'b0, 1'b0, 32'h0));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b1, 32'h2, 32'h40, 32'hDEAD,  1'b0, 32'h0, 1'b0,  1'b0, 12'h0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h341, 32'h40,  1'b1, 1'b0, 1'b0, 32'h0));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b1, 32'h5, 32'h99, 32'h77,  1'b0, 32'h0, 1'b0,  1'b1, 12'h342, 32'h2,  1'b1, 1'b0, 1'b0, 32'h0));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h343, 32'hDEAD,  1'b1, 1'b0, 1'b0, 32'h0));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h300, 32'h1800,  1'b1, 1'b0, 1'b0, 32'h0));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b0, 12'h0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h100));
    // Masked interrupt (MIE clear) does nothing.
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b1, 32'h44, 1'b0,  1'b0, 12'h0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0));
    // Vectored interrupt setup and entry.
    main_q.push_back(mk(1'b1, 12'h300, 32'h8,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h300, 32'h8,  1'b0, 1'b0, 1'b0, 32'h0));
    main_q.push_back(mk(1'b1, 12'h304, 32'h800,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h304, 32'h800,  1'b0, 1'b0, 1'b0, 32'h0));
    main_q.push_back(mk(1'b1, 12'h305, 32'h101,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h305, 32'h101,  1'b0, 1'b0, 1'b0, 32'h0));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b1, 32'h80, 1'b0,  1'b0, 12'h0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b1, 32'h80, 1'b0,  1'b1, 12'h341, 32'h80,  1'b1, 1'b0, 1'b0, 32'h0));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h342, 32'h8000000B,  1'b1, 1'b0, 1'b0, 32'h0));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h343, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h300, 32'h1880,  1'b1, 1'b0, 1'b0, 32'h0));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b0, 12'h0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h12C));
    // mret; the ex write in the accept cycle passes through.
    main_q.push_back(mk(1'b1, 12'h304, 32'h800,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b1,  1'b1, 12'h304, 32'h800,  1'b0, 1'b1, 1'b0, 32'h0));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h300, 32'h1888,  1'b1, 1'b0, 1'b0, 32'h0));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b0, 12'h0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h80));
    // Simultaneous events: exception wins, ex write dropped.
    main_q.push_back(mk(1'b1, 12'h341, 32'h1234,  1'b1, 32'h7, 32'h200, 32'h55,  1'b1, 32'h300, 1'b1,  1'b0, 12'h0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h341, 32'h200,  1'b1, 1'b0, 1'b0, 32'h0));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h342, 32'h7,  1'b1, 1'b0, 1'b0, 32'h0));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h343, 32'h55,  1'b1, 1'b0, 1'b0, 32'h0));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h300, 32'h1880,  1'b1, 1'b0, 1'b0, 32'h0));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b0, 12'h0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h100));
    main_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b1, 32'h60, 1'b0,  1'b0, 12'h0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0));

    // Into W_MTVAL of an interrupt entry, then reset.
    pre_q.push_back(mk(1'b1, 12'h300, 32'h8,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h300, 32'h8,  1'b0, 1'b0, 1'b0, 32'h0));
    pre_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b1, 32'h90, 1'b0,  1'b0, 12'h0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0));
    pre_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h341, 32'h90,  1'b1, 1'b0, 1'b0, 32'h0));
    pre_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h342, 32'h8000000B,  1'b1, 1'b0, 1'b0, 32'h0));

    // After reset: shadows cleared, so irq masked, mret goes to 0, trap base 0.
    post_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b1, 32'h90, 1'b0,  1'b0, 12'h0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0));
    post_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b1,  1'b0, 12'h0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0));
    post_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h300, 32'h1880,  1'b1, 1'b0, 1'b0, 32'h0));
    post_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b0, 12'h0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h0));
    post_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b1, 32'h1, 32'h4, 32'h0,  1'b0, 32'h0, 1'b0,  1'b0, 12'h0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0));
    post_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h341, 32'h4,  1'b1, 1'b0, 1'b0, 32'h0));
    post_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h342, 32'h1,  1'b1, 1'b0, 1'b0, 32'h0));
    post_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h343, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0));
    post_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b1, 12'h300, 32'h1800,  1'b1, 1'b0, 1'b0, 32'h0));
    post_q.push_back(mk(1'b0, 12'h0, 32'h0,  1'b0, 32'h0, 32'h0, 32'h0,  1'b0, 32'h0, 1'b0,  1'b0, 12'h0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h0));

    clear_inputs();
    rst_n = 1'b0;
    #2;
    check_zero("reset_initial");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < main_q.size(); i++) run_vec(main_q[i], $sformatf("main%0d", i));
    for (int i = 0; i < pre_q.size(); i++) run_vec(pre_q[i], $sformatf("pre%0d", i));

    // Now in W_MTVAL; assert reset between edges with every request active.
    ex_csr_we = 1'b1; ex_csr_waddr = 12'h300; ex_csr_wdata = 32'hFF;
    exc_valid = 1'b1; exc_cause = 32'h3; irq_ext = 1'b1; mret_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_async");
    @(posedge clk);
    #1;
    check_zero("reset_mid_held");
    clear_inputs();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < post_q.size(); i++) run_vec(post_q[i], $sformatf("post%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
